alu_multicycle: RTL and testbench

Parametrised, registered successor to the single-cycle combinational ALU in the ARM7TDMI datapath. Adds a valid/ready handshake on both sides, NZCV flags with a correct zero flag, signed and unsigned compare, and an iterative shift-add multiplier taking WIDTH cycles. The execute stage sits between it and the register-file writeback. One operation is in flight at a time.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_mul_iter.sv | 45 ++++
 rtl/alu_multicycle.sv | 127 ++++++++++++
 tb/tb_alu_multicycle.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and flag struct shared by the multicycle ALU
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - shift-add multiplier, one multiplier bit per cycle, LSB first
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  // product already includes the bit being processed this cycle, so the
  // caller can capture it on the same edge that done is seen
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= multiplicand;
      mplier <= multiplier;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end else if (cnt != '0) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - registered ALU with valid/ready handshake, NZCV flags and iterative MUL
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             illegal_op
);

  state_t state, state_next;

  logic             accept;
  logic             is_mul_op;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] alu_res;
  nzcv_t            alu_flags;
  logic             alu_illegal;

  logic [WIDTH-1:0] result_q;
  nzcv_t            flags_q;
  logic             illegal_q;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_mul_op = (alu_control == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (accept && is_mul_op),
    .multiplicand (operand_a),
    .multiplier   (operand_b),
    .done         (mul_done),
    .product      (mul_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = is_mul_op ? MUL : DONE;
      MUL:     if (mul_done) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign sum_ext  = {1'b0, operand_a} + {1'b0, operand_b};
  assign diff_ext = {1'b0, operand_a} - {1'b0, operand_b};

  always_comb begin
    alu_res     = '0;
    alu_flags   = '0;
    alu_illegal = 1'b0;
    case (alu_control)
      OP_AND:  alu_res = operand_a & operand_b;
      OP_OR:   alu_res = operand_a | operand_b;
      OP_XOR:  alu_res = operand_a ^ operand_b;
      OP_ADD: begin
        alu_res     = sum_ext[WIDTH-1:0];
        alu_flags.c = sum_ext[WIDTH];
        alu_flags.v = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                      (sum_ext[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        // ARM carry on subtract is the inverse of the borrow
        alu_res     = diff_ext[WIDTH-1:0];
        alu_flags.c = ~diff_ext[WIDTH];
        alu_flags.v = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                      (diff_ext[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_MUL:  alu_res = '0;
      default: alu_illegal = 1'b1;
    endcase
    alu_flags.n = alu_res[WIDTH-1];
    alu_flags.z = (alu_res == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else if (accept && !is_mul_op) begin
      result_q  <= alu_res;
      flags_q   <= alu_flags;
      illegal_q <= alu_illegal;
    end else if (state == MUL && mul_done) begin
      result_q  <= mul_product;
      flags_q   <= '{n: mul_product[WIDTH-1], z: (mul_product == '0), c: 1'b0, v: 1'b0};
      illegal_q <= 1'b0;
    end
  end

  assign result     = result_q;
  assign flag_n     = flags_q.n;
  assign flag_z     = flags_q.z;
  assign flag_c     = flags_q.c;
  assign flag_v     = flags_q.v;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed self-checking bench for alu_multicycle at WIDTH 32 and 8
module tb_alu_multicycle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv32, ir32, ov32, or32;
  logic [31:0] a32, b32, r32;
  logic [3:0]  op32;
  logic        n32, z32, c32, v32, il32;

  logic        iv8, ir8, ov8, or8;
  logic [7:0]  a8, b8, r8;
  logic [3:0]  op8;
  logic        n8, z8, c8, v8, il8;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
    .operand_a(a32), .operand_b(b32), .alu_control(op32),
    .out_valid(ov32), .out_ready(or32), .result(r32),
    .flag_n(n32), .flag_z(z32), .flag_c(c32), .flag_v(v32), .illegal_op(il32)
  );

  alu_multicycle #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .operand_a(a8), .operand_b(b8), .alu_control(op8),
    .out_valid(ov8), .out_ready(or8), .result(r8),
    .flag_n(n8), .flag_z(z8), .flag_c(c8), .flag_v(v8), .illegal_op(il8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // issue one op with out_ready high, measure latency, check outputs, return to IDLE
  task automatic run_op(input bit w8, input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [3:0] ef,
                        input bit eil, input int elat);
    int lat;
    bit ov;
    @(negedge clk);
    if (w8) begin iv8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
    else    begin iv32 = 1'b1; op32 = op; a32 = a; b32 = b; end
    @(posedge clk); #1;
    iv8 = 1'b0; iv32 = 1'b0;
    lat = 1;
    ov = w8 ? ov8 : ov32;
    while (!ov && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      ov = w8 ? ov8 : ov32;
    end
    check({tag, " latency"}, lat, elat);
    if (w8) begin
      check({tag, " result"}, r8, er[7:0]);
      check({tag, " nzcv"}, {n8, z8, c8, v8}, ef);
      check({tag, " illegal"}, il8, eil);
      check({tag, " in_ready"}, ir8, 1'b0);
    end else begin
      check({tag, " result"}, r32, er);
      check({tag, " nzcv"}, {n32, z32, c32, v32}, ef);
      check({tag, " illegal"}, il32, eil);
      check({tag, " in_ready"}, ir32, 1'b0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    iv32 = 0; or32 = 1'b1; a32 = '0; b32 = '0; op32 = '0;
    iv8  = 0; or8  = 1'b1; a8  = '0; b8  = '0; op8  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("reset in_ready", ir32, 1'b1);
    check("reset out_valid", ov32, 1'b0);
    check("reset result", r32, 32'h0);
    check("reset flags", {n32, z32, c32, v32, il32}, 5'b0);

    run_op(0, "add ovf",   4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001, 0, 1);
    run_op(0, "add carry", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0,         4'b0110, 0, 1);
    run_op(0, "sub eq",    4'b0011, 32'd5, 32'd5,          32'h0,         4'b0110, 0, 1);
    run_op(0, "sub borrow",4'b0011, 32'd0, 32'd1,          32'hFFFF_FFFF, 4'b1000, 0, 1);
    run_op(0, "sltu",      4'b0100, 32'hFFFF_FFFF, 32'h1, 32'h0,         4'b0100, 0, 1);
    run_op(0, "xor",       4'b0110, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 4'b1000, 0, 1);
    run_op(0, "mul",       4'b0101, 32'h0001_0003, 32'h5, 32'h0005_000F, 4'b0000, 0, 33);
    run_op(0, "mul zero",  4'b0101, 32'h0, 32'h1234_5678, 32'h0,         4'b0100, 0, 33);

    // illegal opcode under back-pressure; requests during the hold are ignored
    or32 = 1'b0;
    @(negedge clk);
    iv32 = 1'b1; op32 = 4'b1010; a32 = 32'd3; b32 = 32'd4;
    @(posedge clk); #1;
    iv32 = 1'b0;
    check("illegal out_valid", ov32, 1'b1);
    check("illegal outputs", {r32, n32, z32, c32, v32, il32}, {32'h0, 4'b0100, 1'b1});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iv32 = 1'b1; op32 = 4'b0010; a32 = 32'd1; b32 = 32'd1;
      @(posedge clk); #1;
      iv32 = 1'b0;
      check("hold stable", {ov32, ir32, r32, n32, z32, c32, v32, il32},
            {1'b1, 1'b0, 32'h0, 4'b0100, 1'b1});
    end
    @(negedge clk) or32 = 1'b1;
    @(posedge clk); #1;
    check("release in_ready", ir32, 1'b1);
    check("release out_valid", ov32, 1'b0);

    run_op(0, "slt",       4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1,         4'b0000, 0, 1);

    // reset in the tenth MUL cycle
    @(negedge clk);
    iv32 = 1'b1; op32 = 4'b0101; a32 = 32'd7; b32 = 32'd9;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid mul in_ready", ir32, 1'b0);
    rst = 1'b1;
    #1;
    check("abort in_ready", ir32, 1'b1);
    check("abort out_valid", ov32, 1'b0);
    check("abort result", r32, 32'h0);
    @(negedge clk) rst = 1'b0;
    run_op(0, "and",       4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 4'b0000, 0, 1);

    run_op(1, "w8 add",    4'b0010, 32'h7F, 32'h01, 32'h80, 4'b1001, 0, 1);
    run_op(1, "w8 mul",    4'b0101, 32'h13, 32'h05, 32'h5F, 4'b0000, 0, 9);
    run_op(1, "w8 mul ff", 4'b0101, 32'hFF, 32'hFF, 32'h01, 4'b0000, 0, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
